// File: rtl/pulse_link_pkg.sv
// Shared definitions for the pulse-count link: FSM encoding, default widths, counter sizing.
package pulse_link_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int DEF_CNT_W = 4;
  localparam int DEF_DIV   = 3;

  // Width needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Wrapping counter 0..N-1 with synchronous clear; at_max flags the terminal count.
module mod_n_counter #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         at_max
);

  assign at_max = (count == W'(N - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= at_max ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/pulse_burst_generator.sv
// Emits a requested number of single-cycle pulses separated by a fixed gap,
// marking every DIV-th pulse; all outputs decode from registered state.
module pulse_burst_generator
  import pulse_link_pkg::*;
#(
  parameter int CNT_W      = DEF_CNT_W,
  parameter int GAP_CYCLES = 1,
  parameter int DIV        = DEF_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CNT_W-1:0] req_len,
  output logic             pulse_out,
  output logic             mark_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sent_cnt
);

  localparam int MARK_W = cnt_width(DIV);
  localparam int GAP_W  = cnt_width(GAP_CYCLES);

  logic [1:0]       state;
  logic [CNT_W-1:0] len_q;
  logic             accept;
  logic             last_pulse;
  logic [MARK_W-1:0] mark_count;
  logic             mark_at_max;
  logic [GAP_W-1:0] gap_count;
  logic             gap_at_max;
  logic             unused_counts;

  assign accept     = req_valid && (state == ST_IDLE);
  assign last_pulse = ((sent_cnt + CNT_W'(1)) == len_q);

  mod_n_counter #(.N(DIV), .W(MARK_W)) u_mark_cnt (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept),
    .en     (state == ST_PULSE),
    .count  (mark_count),
    .at_max (mark_at_max)
  );

  // The gap timer wraps to zero as it leaves GAP, so every gap starts from zero.
  generate
    if (GAP_CYCLES > 0) begin : g_gap
      mod_n_counter #(.N(GAP_CYCLES), .W(GAP_W)) u_gap_cnt (
        .clk    (clk),
        .reset  (reset),
        .clr    (accept),
        .en     (state == ST_GAP),
        .count  (gap_count),
        .at_max (gap_at_max)
      );
    end else begin : g_no_gap
      assign gap_count  = '0;
      assign gap_at_max = 1'b1;
    end
  endgenerate

  assign unused_counts = ^{mark_count, gap_count};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      len_q    <= '0;
      sent_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            len_q    <= req_len;
            sent_cnt <= '0;
            state    <= (req_len != '0) ? ST_PULSE : ST_DONE;
          end
        end
        ST_PULSE: begin
          sent_cnt <= sent_cnt + CNT_W'(1);
          if (last_pulse)           state <= ST_DONE;
          else if (GAP_CYCLES == 0) state <= ST_PULSE;
          else                      state <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_at_max) state <= ST_PULSE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign pulse_out = (state == ST_PULSE);
  assign mark_out  = (state == ST_PULSE) && mark_at_max;
  assign done      = (state == ST_DONE);

endmodule
